// File: rtl/cp_inst_mem_loader.sv
// Loads CP instructions from a narrow host bus into a dual-port instruction memory,
// assembling LOAD_WIDTH beats per instruction, while serving 1-cycle CP fetches.
module cp_inst_mem_loader #(
    parameter int CP_I_WIDTH      = 56,
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter int LOAD_WIDTH      = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic [IMEM_ADDR_WIDTH-1:0] load_base,
    input  logic [IMEM_ADDR_WIDTH:0]   load_count,
    input  logic                       load_valid,
    input  logic [LOAD_WIDTH-1:0]      load_data,
    output logic                       load_ready,
    output logic                       load_busy,
    output logic                       load_done,
    input  logic                       fetch_en,
    input  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr,
    output logic [CP_I_WIDTH-1:0]      fetch_data,
    output logic                       fetch_valid
);
    localparam int BEATS     = (CP_I_WIDTH + LOAD_WIDTH - 1) / LOAD_WIDTH;
    localparam int DEPTH     = 1 << IMEM_ADDR_WIDTH;
    localparam int COLLECT_W = (BEATS > 1) ? (BEATS - 1) * LOAD_WIDTH : LOAD_WIDTH;
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                  state_reg;
    logic [3:0]                  beat_reg;
    logic [IMEM_ADDR_WIDTH-1:0]  addr_reg;
    logic [IMEM_ADDR_WIDTH:0]    remaining_reg;
    logic [COLLECT_W-1:0]        collect_reg;
    logic [BEATS*LOAD_WIDTH-1:0] assembled;
    logic [CP_I_WIDTH-1:0]       wr_data;
    logic                        beat_fire;
    logic                        wr_en;
    logic [CP_I_WIDTH-1:0]       mem [DEPTH];

    assign load_ready = (state_reg == LOAD);
    assign load_busy  = (state_reg != IDLE);
    assign load_done  = (state_reg == DONE);

    assign beat_fire = (state_reg == LOAD) && load_valid;
    assign wr_en     = beat_fire && (beat_reg == LAST_BEAT);

    // The final beat is taken straight from the bus so the commit happens on its own edge.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            if (gi == BEATS - 1) begin : g_last
                assign assembled[gi*LOAD_WIDTH +: LOAD_WIDTH] = load_data;
            end else begin : g_held
                assign assembled[gi*LOAD_WIDTH +: LOAD_WIDTH] = collect_reg[gi*LOAD_WIDTH +: LOAD_WIDTH];
            end
        end
        if (BEATS * LOAD_WIDTH > CP_I_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^assembled[BEATS*LOAD_WIDTH-1:CP_I_WIDTH];
        end
        if (BEATS == 1) begin : g_no_collect
            logic unused_collect;
            assign unused_collect = ^collect_reg;
        end
    endgenerate

    assign wr_data = assembled[CP_I_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collect_reg <= '0;
        end else begin
            for (int k = 0; k < BEATS - 1; k++) begin
                if (beat_fire && beat_reg == 4'(k)) begin
                    collect_reg[k*LOAD_WIDTH +: LOAD_WIDTH] <= load_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        addr_reg      <= load_base;
                        remaining_reg <= load_count;
                        beat_reg      <= '0;
                        state_reg     <= (load_count != '0) ? LOAD : DONE;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (beat_reg == LAST_BEAT) begin
                            beat_reg      <= '0;
                            addr_reg      <= addr_reg + 1'b1;
                            remaining_reg <= remaining_reg - 1'b1;
                            if (remaining_reg == (IMEM_ADDR_WIDTH+1)'(1)) begin
                                state_reg <= DONE;
                            end
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr_reg] <= wr_data;
        end
    end

    // Write-first: a fetch of the slot being committed this edge sees the new instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_en;
            if (fetch_en) begin
                fetch_data <= (wr_en && fetch_addr == addr_reg) ? wr_data : mem[fetch_addr];
            end
        end
    end
endmodule

// File: doc/cp_inst_mem_loader.md
CP_INST_MEM_LOADER -- requirements
Module: cp_inst_mem_loader

Interface
REQ-001 SHALL have parameter CP_I_WIDTH, default 56, CP instruction width in bits.
REQ-002 SHALL have parameter IMEM_ADDR_WIDTH, default 9, giving depth 2^IMEM_ADDR_WIDTH instructions.
REQ-003 SHALL have parameter LOAD_WIDTH, default 32, host load bus width; derived BEATS = ceil(CP_I_WIDTH/LOAD_WIDTH), legal range 1..8.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_start  in  1  one-cycle request to begin a load burst.
REQ-007 SHALL have port load_base  in  IMEM_ADDR_WIDTH  first instruction address, sampled with load_start.
REQ-008 SHALL have port load_count  in  IMEM_ADDR_WIDTH+1  number of instructions, sampled with load_start.
REQ-009 SHALL have port load_valid  in  1  host beat valid.
REQ-010 SHALL have port load_data  in  LOAD_WIDTH  host beat data.
REQ-011 SHALL have port load_ready  out  1  block accepts a beat; beat transfers when load_valid && load_ready.
REQ-012 SHALL have port load_busy  out  1  burst in progress.
REQ-013 SHALL have port load_done  out  1  one-cycle pulse at burst completion.
REQ-014 SHALL have port fetch_en  in  1  CP fetch request.
REQ-015 SHALL have port fetch_addr  in  IMEM_ADDR_WIDTH  CP fetch address.
REQ-016 SHALL have port fetch_data  out  CP_I_WIDTH  registered instruction.
REQ-017 SHALL have port fetch_valid  out  1  fetch_data updated this cycle.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-019 IDLE: load_start with load_count != 0 -> LOAD; load_count == 0 -> DONE with no writes; otherwise stay.
REQ-020 load_start SHALL be ignored outside IDLE; load_base/load_count re-sampled only on an accepted start.
REQ-021 load_ready SHALL equal 1 exactly in LOAD; load_busy SHALL equal 1 in LOAD and DONE.
REQ-022 Beats SHALL pack little-endian: beat k fills bits [k*LOAD_WIDTH +: LOAD_WIDTH]; bits above CP_I_WIDTH-1 in the last beat discarded.
REQ-023 Memory write SHALL occur on the edge accepting beat BEATS-1 of each instruction; no partial instruction is ever written.
REQ-024 Write address SHALL start at load_base and increment by 1 per committed instruction, modulo 2^IMEM_ADDR_WIDTH.
REQ-025 LOAD -> DONE on the edge committing the load_count-th instruction; DONE -> IDLE after one cycle; load_done = 1 only in DONE.
REQ-026 Cycles with load_valid low SHALL leave beat counter, address and remaining count unchanged.
REQ-027 Fetch latency SHALL be 1 cycle: fetch_en at edge n -> fetch_data and fetch_valid = 1 after edge n+1.
REQ-028 fetch_valid SHALL be 0 in any cycle not following a fetch_en; fetch_data SHALL hold its last value when fetch_en is low.
REQ-029 Fetch SHALL be allowed in every state; a fetch of the address being committed on the same edge SHALL return the new instruction (write-first forwarding).
REQ-030 Memory array SHALL be a simple dual-port RAM with no reset on contents.

Reset
REQ-031 On reset assertion: state IDLE; load_ready, load_busy, load_done, fetch_valid = 0; fetch_data = 0; beat/address/count registers cleared, asynchronously.
REQ-032 Reset mid-burst SHALL abandon the burst; already-committed instructions retained, partially collected instruction discarded.
REQ-033 Deassertion SHALL leave the block in IDLE, ready to accept load_start on the next edge.

Verification (CP_I_WIDTH=56, LOAD_WIDTH=32, IMEM_ADDR_WIDTH=9)
REQ-034 Start base=0x010 count=1, beats 0x89ABCDEF, 0xFF123456 -> load_done pulse cycle after 2nd beat; fetch 0x010 returns 0x12345689ABCDEF.
REQ-035 Same load with load_valid low 3 cycles between beats -> identical memory content, exactly one write, load_ready held 1 throughout.
REQ-036 Start base=0x1FF count=2 -> instructions written at 0x1FF then 0x000; 0x001 unchanged.
REQ-037 fetch_en at 0x010 on the commit edge of new data 0x00000000000001 -> next cycle fetch_data = 0x00000000000001, fetch_valid = 1.
REQ-038 Reset asserted after 1 of 2 beats of instruction 2 at base 0x020 -> load_busy 0 immediately; 0x020 holds instruction 1, 0x021 unchanged.
REQ-039 Start with count=0 -> load_done pulse next cycle, load_ready never 1, no memory change; load_start during DONE ignored.
